// File: rtl/memory_stage_pkg.sv
// Shared types for the MEM stage: pipeline registers, memory mode encoding and the bus FSM states.
// MEM_ALIGN_CHECK_EN adds the memFault field to REG_MEM_WB.
package memory_stage_pkg;

  localparam int XLEN = 64;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2,
    SIZE_D = 2'd3
  } mem_size_e;

  typedef struct packed {
    logic      is_unsigned;
    mem_size_e size;
  } MEM_MODE;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_REQ  = 2'd1,
    MEM_DONE = 2'd2
  } mem_state_e;

  typedef struct packed {
    logic            valid;
    logic            isWriteBack;
    logic [4:0]      wd;
    logic [XLEN-1:0] aluOut;
    logic [XLEN-1:0] rs2;
    logic            isMemRead;
    logic            isMemWrite;
    MEM_MODE         memMode;
    logic [XLEN-1:0] instrAddr;
    logic [31:0]     instr;
    logic            isBranch;
    logic [XLEN-1:0] pcBranch;
  } REG_EX_MEM;

  typedef struct packed {
    logic            valid;
    logic            isWriteBack;
    logic [4:0]      wd;
    logic [XLEN-1:0] wbData;
    logic [XLEN-1:0] instrAddr;
    logic [31:0]     instr;
    logic            isBranch;
    logic [XLEN-1:0] pcBranch;
`ifdef MEM_ALIGN_CHECK_EN
    logic            memFault;
`endif
  } REG_MEM_WB;

  typedef struct packed {
    logic            valid;
    logic            isWb;
    logic [4:0]      wd;
    logic [XLEN-1:0] wdData;
  } FORWARD_SOURCE;

  // Byte-enable pattern for an access of the given size starting at lane 0.
  function automatic logic [7:0] size_mask(input mem_size_e size);
    case (size)
      SIZE_B:  return 8'h01;
      SIZE_H:  return 8'h03;
      SIZE_W:  return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/memory_stage_mem_align.sv
// Combinational lane steering: store data/strobe shifted to the beat lane, load beat shifted down and extended.
// Zero latency, no flow control; lanes beyond byte 7 fall off the end of the beat.
module memory_stage_mem_align
  import memory_stage_pkg::*;
(
  input  logic [2:0]      addr_lo,
  input  MEM_MODE         mode,
  input  logic [XLEN-1:0] store_data,
  input  logic [XLEN-1:0] load_beat,
  output logic [XLEN-1:0] store_lane,
  output logic [7:0]      strobe,
  output logic [XLEN-1:0] load_ext
);

  logic [5:0]      shamt;
  logic [XLEN-1:0] raw;
  logic            sext;

  assign shamt      = {addr_lo, 3'b000};
  assign store_lane = store_data << shamt;
  assign strobe     = size_mask(mode.size) << addr_lo;
  assign raw        = load_beat >> shamt;
  assign sext       = ~mode.is_unsigned;

  always_comb begin
    load_ext = raw;
    case (mode.size)
      SIZE_B:  load_ext = {{56{sext & raw[7]}},  raw[7:0]};
      SIZE_H:  load_ext = {{48{sext & raw[15]}}, raw[15:0]};
      SIZE_W:  load_ext = {{32{sext & raw[31]}}, raw[31:0]};
      default: load_ext = raw;
    endcase
  end

endmodule

// File: rtl/memory_stage.sv
// MEM stage: one bus transaction per load/store, IDLE->REQ->DONE; non-mem ops pass in 1 cycle, mem ops 1 + bus latency.
// Stalls the pipeline via ok_to_proceed until the response lands; MEM_ALIGN_CHECK_EN faults misaligned accesses.
module memory_stage
  import memory_stage_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  REG_EX_MEM       moduleIn,
  output REG_MEM_WB       moduleOut,
  output FORWARD_SOURCE   forwardSource,
  output logic            ok_to_proceed,
  input  logic            ok_to_proceed_overall,
  output logic            dreq_valid,
  output logic [XLEN-1:0] dreq_addr,
  output logic            dreq_write,
  output logic [1:0]      dreq_size,
  output logic [7:0]      dreq_strobe,
  output logic [XLEN-1:0] dreq_data,
  input  logic            dresp_ok,
  input  logic [XLEN-1:0] dresp_data
);

  mem_state_e      state;
  logic [XLEN-1:0] load_beat_q;
  logic [XLEN-1:0] load_ext;
  logic [XLEN-1:0] wb_data;
  logic            mem_op;
  logic            fault;
  logic            advance;

  assign mem_op = moduleIn.valid & (moduleIn.isMemRead | moduleIn.isMemWrite);

`ifdef MEM_ALIGN_CHECK_EN
  logic [2:0] align_mask;
  assign align_mask = 3'((4'd1 << moduleIn.memMode.size) - 4'd1);
  assign fault      = mem_op & (|(moduleIn.aluOut[2:0] & align_mask));
`else
  assign fault = 1'b0;
`endif

  memory_stage_mem_align u_align (
    .addr_lo    (moduleIn.aluOut[2:0]),
    .mode       (moduleIn.memMode),
    .store_data (moduleIn.rs2),
    .load_beat  (load_beat_q),
    .store_lane (dreq_data),
    .strobe     (dreq_strobe),
    .load_ext   (load_ext)
  );

  // Gated by rst so an abandoned request drops in the same cycle reset arrives.
  assign dreq_valid = ~rst & (((state == MEM_IDLE) & mem_op & ~fault) | (state == MEM_REQ));
  assign dreq_addr  = moduleIn.aluOut;
  assign dreq_write = moduleIn.isMemWrite;
  assign dreq_size  = moduleIn.memMode.size;

  assign ok_to_proceed = ~(((state == MEM_IDLE) & mem_op) | (state == MEM_REQ));
  assign advance       = ok_to_proceed & ok_to_proceed_overall;
  assign wb_data       = ((state == MEM_DONE) & moduleIn.isMemRead) ? load_ext : moduleIn.aluOut;

  assign forwardSource.valid  = moduleIn.valid & (moduleIn.wd != 5'd0);
  assign forwardSource.isWb   = moduleIn.isWriteBack & ~fault;
  assign forwardSource.wd     = moduleIn.wd;
  assign forwardSource.wdData = wb_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= MEM_IDLE;
      load_beat_q <= '0;
      moduleOut   <= '0;
    end else begin
      case (state)
        MEM_IDLE: if (mem_op) state <= fault ? MEM_DONE : MEM_REQ;
        MEM_REQ: begin
          if (dresp_ok) begin
            load_beat_q <= dresp_data;
            state       <= MEM_DONE;
          end
        end
        // Wait here while other stages stall; the access is not reissued.
        MEM_DONE: if (ok_to_proceed_overall) state <= MEM_IDLE;
        default:  state <= MEM_IDLE;
      endcase

      if (advance) begin
        moduleOut.valid       <= moduleIn.valid;
        moduleOut.isWriteBack <= moduleIn.isWriteBack & ~fault;
        moduleOut.wd          <= moduleIn.wd;
        moduleOut.wbData      <= wb_data;
        moduleOut.instrAddr   <= moduleIn.instrAddr;
        moduleOut.instr       <= moduleIn.instr;
        moduleOut.isBranch    <= moduleIn.isBranch;
        moduleOut.pcBranch    <= moduleIn.pcBranch;
`ifdef MEM_ALIGN_CHECK_EN
        moduleOut.memFault    <= fault;
`endif
      end
    end
  end

endmodule
